// File: rtl/meduram_wr_scheduler.sv
// Dual-port RAM write scheduler.
// Picks up to two write requesters per cycle in round-robin order and
// forwards them to the two RAM write ports one cycle later. The second
// grant must target a different address than the first, so both ports
// never write the same location in the same cycle.
//
// Handshake: requester i transfers when req_valid[i] && req_ready[i] at a
// rising aclk edge. req_ready is a pure function of req_valid, req_addr,
// the round-robin pointer and aresetn. It never waits on a ready of its
// own, and it is forced low while aresetn is low. A requester holds valid,
// addr and data until it transfers.
module meduram_wr_scheduler #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int NB_REQ     = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NB_REQ-1:0]            req_valid,
    output logic [NB_REQ-1:0]            req_ready,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_REQ*DATA_WIDTH-1:0] req_data,
    output logic                         wren1,
    output logic [ADDR_WIDTH-1:0]        wraddr1,
    output logic [DATA_WIDTH-1:0]        wrdata1,
    output logic                         wren2,
    output logic [ADDR_WIDTH-1:0]        wraddr2,
    output logic [DATA_WIDTH-1:0]        wrdata2,
    output logic [7:0]                   conflict_cnt
);

    localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef logic [PTR_W-1:0] idx_t;

    // Unpacked views of the requester buses
    logic [ADDR_WIDTH-1:0] addr_arr [NB_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NB_REQ];

    for (genvar i = 0; i < NB_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    idx_t                  ptr;
    logic                  a_found;
    logic                  b_found;
    logic                  skipped;
    idx_t                  a_idx;
    idx_t                  b_idx;
    logic [ADDR_WIDTH-1:0] a_addr;

    // Next index after v, wrapping at NB_REQ (NB_REQ need not be a power of 2)
    function automatic idx_t wrap_inc(input idx_t v);
        logic [PTR_W:0] s;
        s = {1'b0, v} + (PTR_W+1)'(1);
        if (s >= (PTR_W+1)'(NB_REQ)) begin
            s = '0;
        end
        return s[PTR_W-1:0];
    endfunction

    // Round-robin scan from ptr: grant A is the first valid requester.
    // Grant B is the next valid requester whose address differs from A's.
    // Same-address requesters passed over before B is found are deferred.
    always_comb begin
        logic [PTR_W:0] scan_w;
        idx_t           scan_idx;
        scan_w   = '0;
        scan_idx = '0;
        a_found  = 1'b0;
        b_found  = 1'b0;
        skipped  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        a_addr   = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            scan_w = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_w >= (PTR_W+1)'(NB_REQ)) begin
                scan_w = scan_w - (PTR_W+1)'(NB_REQ);
            end
            scan_idx = scan_w[PTR_W-1:0];
            if (req_valid[scan_idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = scan_idx;
                    a_addr  = addr_arr[scan_idx];
                end else if (!b_found) begin
                    if (addr_arr[scan_idx] == a_addr) begin
                        skipped = 1'b1;
                    end else begin
                        b_found = 1'b1;
                        b_idx   = scan_idx;
                    end
                end
            end
        end
    end

    // Grants become ready bits. Reset blocks every transfer.
    always_comb begin
        req_ready = '0;
        if (aresetn) begin
            if (a_found) begin
                req_ready[a_idx] = 1'b1;
            end
            if (b_found) begin
                req_ready[b_idx] = 1'b1;
            end
        end
    end

    // Register the granted writes onto the RAM ports. Advance the pointer
    // past the last grant. Count the cycles that deferred a requester.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ptr          <= '0;
            wren1        <= 1'b0;
            wren2        <= 1'b0;
            wraddr1      <= '0;
            wraddr2      <= '0;
            wrdata1      <= '0;
            wrdata2      <= '0;
            conflict_cnt <= '0;
        end else begin
            wren1 <= a_found;
            wren2 <= b_found;
            if (a_found) begin
                wraddr1 <= addr_arr[a_idx];
                wrdata1 <= data_arr[a_idx];
            end
            if (b_found) begin
                wraddr2 <= addr_arr[b_idx];
                wrdata2 <= data_arr[b_idx];
            end
            if (b_found) begin
                ptr <= wrap_inc(b_idx);
            end else if (a_found) begin
                ptr <= wrap_inc(a_idx);
            end
            if (skipped && (conflict_cnt != 8'hFF)) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_meduram_wr_scheduler.sv
// Bench for meduram_wr_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based behavioural model of the grant rules.
module tb_meduram_wr_scheduler;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NB = 4;
    localparam int PW = AW + DW;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    // ---------------- DUT ----------------
    logic [NB-1:0]    req_valid;
    logic [NB-1:0]    req_ready;
    logic [NB*AW-1:0] req_addr;
    logic [NB*DW-1:0] req_data;
    logic             wren1;
    logic [AW-1:0]    wraddr1;
    logic [DW-1:0]    wrdata1;
    logic             wren2;
    logic [AW-1:0]    wraddr2;
    logic [DW-1:0]    wrdata2;
    logic [7:0]       conflict_cnt;

    logic [NB-1:0] tb_valid;
    logic [AW-1:0] tb_addr [NB];
    logic [DW-1:0] tb_data [NB];

    assign req_valid = tb_valid;
    for (genvar i = 0; i < NB; i++) begin : g_pack
        assign req_addr[i*AW +: AW] = tb_addr[i];
        assign req_data[i*DW +: DW] = tb_data[i];
    end

    meduram_wr_scheduler #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NB_REQ    (NB)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .wren1       (wren1),
        .wraddr1     (wraddr1),
        .wrdata1     (wrdata1),
        .wren2       (wren2),
        .wraddr2     (wraddr2),
        .wrdata2     (wrdata2),
        .conflict_cnt(conflict_cnt)
    );

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_ptr;
    int            m_cnt;
    bit            model_known = 1'b0;
    logic [PW-1:0] exp1_q [$];
    logic [PW-1:0] exp2_q [$];
    logic [PW-1:0] last1;
    logic [PW-1:0] last2;
    logic [NB-1:0] granted_mask = '0;
    int            g_a;
    int            g_b;
    bit            g_skip;

    // List the valid requesters in round-robin order from m_ptr. The head
    // is grant A. Grant B is the first later entry with a different address.
    // Any entries ahead of B (or all of them if there is no B) share A's
    // address and are deferred.
    task automatic model_grants();
        int cand [$];
        int r [$];
        int a_ix;
        g_a    = -1;
        g_b    = -1;
        g_skip = 1'b0;
        if (aresetn !== 1'b1) return;
        for (int k = 0; k < NB; k++) begin
            if (tb_valid[(m_ptr + k) % NB]) cand.push_back((m_ptr + k) % NB);
        end
        if (cand.size() == 0) return;
        a_ix = cand.pop_front();
        g_a  = a_ix;
        r = cand.find_first_index(x) with (tb_addr[x] != tb_addr[a_ix]);
        if (r.size() == 0) begin
            g_skip = (cand.size() > 0);
        end else begin
            g_b    = cand[r[0]];
            g_skip = (r[0] > 0);
        end
    endtask

    // Scoreboard: compare on every falling edge, then advance the model over
    // the following rising edge (inputs are stable between the two)
    always @(negedge aclk) begin
        logic [PW-1:0] e;
        logic [NB-1:0] exp_ready;
        model_grants();
        exp_ready = '0;
        if (g_a >= 0) exp_ready[g_a] = 1'b1;
        if (g_b >= 0) exp_ready[g_b] = 1'b1;
        if (model_known) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                chk("wren1", 32'(wren1), 1);
                chk("port1", 32'({wraddr1, wrdata1}), 32'(e));
                last1 = e;
            end else begin
                chk("wren1_idle", 32'(wren1), 0);
                chk("port1_hold", 32'({wraddr1, wrdata1}), 32'(last1));
            end
            if (exp2_q.size() > 0) begin
                e = exp2_q.pop_front();
                chk("wren2", 32'(wren2), 1);
                chk("port2", 32'({wraddr2, wrdata2}), 32'(e));
                last2 = e;
            end else begin
                chk("wren2_idle", 32'(wren2), 0);
                chk("port2_hold", 32'({wraddr2, wrdata2}), 32'(last2));
            end
            if (wren1 === 1'b1 && wren2 === 1'b1)
                chk("port_addr_distinct", 32'(wraddr1 != wraddr2), 1);
            chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        end
        granted_mask = exp_ready;
        if (aresetn !== 1'b1) begin
            m_ptr = 0;
            m_cnt = 0;
            last1 = '0;
            last2 = '0;
            exp1_q.delete();
            exp2_q.delete();
            model_known = 1'b1;
        end else if (model_known) begin
            if (g_a >= 0) begin
                exp1_q.push_back({tb_addr[g_a], tb_data[g_a]});
                m_ptr = (((g_b >= 0) ? g_b : g_a) + 1) % NB;
            end
            if (g_b >= 0) exp2_q.push_back({tb_addr[g_b], tb_data[g_b]});
            if (g_skip) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        @(negedge aclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_valid[i] = 1'b1;
        tb_addr[i]  = a;
        tb_data[i]  = d;
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        tb_valid = '0;
        step();
        aresetn = 1'b1;
    endtask

    task automatic chk_port1(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({name, "_wren1"}, 32'(wren1), 1);
        chk({name, "_port1"}, 32'({wraddr1, wrdata1}), 32'({a, d}));
    endtask

    task automatic chk_port2(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({name, "_wren2"}, 32'(wren2), 1);
        chk({name, "_port2"}, 32'({wraddr2, wrdata2}), 32'({a, d}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        aresetn  = 1'b0;
        tb_valid = '1;
        for (int i = 0; i < NB; i++) begin
            tb_addr[i] = '0;
            tb_data[i] = '0;
        end

        // Reset held two cycles with every requester valid
        settle();
        chk("rst_ready", 32'(req_ready), 0);
        step();
        chk("rst_wren1", 32'(wren1), 0);
        chk("rst_wren2", 32'(wren2), 0);
        chk("rst_cnt", 32'(conflict_cnt), 0);
        aresetn = 1'b1;

        // Full load, distinct addresses
        for (int i = 0; i < NB; i++) set_req(i, AW'(i), DW'(8'hA0 + i));
        settle();
        chk("full_ready1", 32'(req_ready), 32'h3);
        step();
        chk_port1("full1", 3'd0, 8'hA0);
        chk_port2("full1", 3'd1, 8'hA1);
        tb_valid[0] = 1'b0;
        tb_valid[1] = 1'b0;
        settle();
        chk("full_ready2", 32'(req_ready), 32'hC);
        step();
        chk_port1("full2", 3'd2, 8'hA2);
        chk_port2("full2", 3'd3, 8'hA3);
        tb_valid = '0;
        set_req(0, 3'd4, 8'h50);
        set_req(1, 3'd4, 8'h51);
        settle();
        chk("full_ptr0_ready", 32'(req_ready), 32'h1);
        step();
        tb_valid[0] = 1'b0;
        settle();
        chk("full_deferred_ready", 32'(req_ready), 32'h2);
        step();
        tb_valid = '0;
        do_reset();

        // Same-address deferral
        set_req(0, 3'd5, 8'h11);
        set_req(1, 3'd5, 8'h22);
        set_req(2, 3'd6, 8'h33);
        settle();
        chk("same_ready1", 32'(req_ready), 32'h5);
        step();
        chk("same_cnt", 32'(conflict_cnt), 1);
        chk_port1("same1", 3'd5, 8'h11);
        chk_port2("same1", 3'd6, 8'h33);
        tb_valid[0] = 1'b0;
        tb_valid[2] = 1'b0;
        settle();
        chk("same_ready2", 32'(req_ready), 32'h2);
        step();
        chk_port1("same2", 3'd5, 8'h22);
        chk("same2_wren2", 32'(wren2), 0);
        tb_valid = '0;
        do_reset();

        // Single requester at the far end of the scan
        set_req(3, 3'd3, 8'h44);
        settle();
        chk("wrap_ready", 32'(req_ready), 32'h8);
        step();
        chk_port1("wrap", 3'd3, 8'h44);
        chk("wrap_wren2", 32'(wren2), 0);
        tb_valid = '0;
        set_req(0, 3'd2, 8'h60);
        set_req(1, 3'd2, 8'h61);
        settle();
        chk("wrap_ptr0_ready", 32'(req_ready), 32'h1);
        step();
        tb_valid[0] = 1'b0;
        step();
        tb_valid = '0;

        // Reset in a granting cycle (pointer is non-zero beforehand)
        for (int i = 0; i < NB; i++) set_req(i, AW'(i), DW'(8'hC0 + i));
        aresetn = 1'b0;
        settle();
        chk("midrst_ready", 32'(req_ready), 0);
        step();
        chk("midrst_wren1", 32'(wren1), 0);
        chk("midrst_wren2", 32'(wren2), 0);
        aresetn = 1'b1;
        settle();
        chk("midrst_ptr0_ready", 32'(req_ready), 32'h3);
        step();
        tb_valid = '0;
        do_reset();

        // Counter saturation: every requester at the same address
        for (int i = 0; i < NB; i++) set_req(i, 3'd7, DW'(i));
        for (int c = 0; c < 300; c++) step();
        chk("sat_cnt", 32'(conflict_cnt), 255);
        for (int c = 0; c < 5; c++) step();
        chk("sat_hold", 32'(conflict_cnt), 255);
        tb_valid = '0;
        do_reset();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            step();
            aresetn = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NB; i++) begin
                if (granted_mask[i]) tb_valid[i] = 1'b0;
                if (!tb_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, AW'($urandom_range(0, 3)), DW'($urandom));
            end
        end
        aresetn  = 1'b1;
        tb_valid = '0;
        step();
        step();
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the run must end on its own
    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
